// File: rtl/status_register_unit_if.sv
// ============================================================================
// status_register_unit_if : EXE/ID flag-path signals of the status register unit
// Rev 1.0
// ============================================================================
`default_nettype none

interface status_register_unit_if #(
   parameter int CNT_W = 16
);
   logic             exe_valid;
   logic             exe_s;
   logic [3:0]       alu_flags;
   logic             id_valid;
   logic [3:0]       id_cond;
   logic [3:0]       sr_id;
   logic [3:0]       sr_q;
   logic             flag_hazard;
   logic [CNT_W-1:0] flag_wr_cnt;

   // Pipeline side: drives EXE/ID state, consumes flags and the stall request.
   modport master (
      output exe_valid, exe_s, alu_flags, id_valid, id_cond,
      input  sr_id, sr_q, flag_hazard, flag_wr_cnt
   );

   modport slave (
      input  exe_valid, exe_s, alu_flags, id_valid, id_cond,
      output sr_id, sr_q, flag_hazard, flag_wr_cnt
   );
endinterface

`default_nettype wire

// File: rtl/status_register_unit.sv
// ============================================================================
// status_register_unit : architectural NZCV register with EXE->ID bypass or stall
// Rev 1.0
// ============================================================================
`default_nettype none

module status_register_unit #(
   parameter int FORWARD_EN = 1,
   parameter int CNT_W      = 16
) (
   input  wire logic              clk,
   input  wire logic              rst_n,
   status_register_unit_if.slave  bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic             wr;
   logic             uses_flags;
   logic [3:0]       sr_reg;
   logic [CNT_W-1:0] wr_cnt;

   assign wr         = bus.exe_valid & bus.exe_s;
   // AL and the unconditional space never consult the flags.
   assign uses_flags = bus.id_valid & (bus.id_cond != 4'b1110) & (bus.id_cond != 4'b1111);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sr_reg <= 4'b0000;
         wr_cnt <= '0;
      end else if (wr) begin
         sr_reg <= bus.alu_flags;
         if (wr_cnt != CNT_MAX) begin
            wr_cnt <= wr_cnt + CNT_ONE;
         end
      end
   end

   assign bus.sr_id       = ((FORWARD_EN != 0) && wr) ? bus.alu_flags : sr_reg;
   assign bus.flag_hazard = (FORWARD_EN == 0) ? (uses_flags & wr) : 1'b0;
   assign bus.sr_q        = sr_reg;
   assign bus.flag_wr_cnt = wr_cnt;

endmodule

`default_nettype wire

// File: tb/tb_status_register_unit.sv
// ============================================================================
// tb_status_register_unit : directed checks of bypass (u_fwd) and stall (u_stl) builds
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_status_register_unit;

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;

   status_register_unit_if #(.CNT_W(16)) bus_f ();
   status_register_unit_if #(.CNT_W(4))  bus_s ();

   status_register_unit #(.FORWARD_EN(1), .CNT_W(16)) u_fwd (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_f.slave)
   );

   status_register_unit #(.FORWARD_EN(0), .CNT_W(4)) u_stl (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_s.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic v, input logic s, input logic [3:0] f,
                        input logic idv, input logic [3:0] cond);
      bus_f.exe_valid = v;   bus_s.exe_valid = v;
      bus_f.exe_s     = s;   bus_s.exe_s     = s;
      bus_f.alu_flags = f;   bus_s.alu_flags = f;
      bus_f.id_valid  = idv; bus_s.id_valid  = idv;
      bus_f.id_cond   = cond; bus_s.id_cond  = cond;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      drive(1'b1, 1'b1, 4'hF, 1'b0, 4'hE);
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 1'b0, 4'h0, 1'b0, 4'hE);
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      vectors++;
      if (bus_f.sr_q !== 4'h0 || bus_f.flag_wr_cnt !== 16'd0) begin
         miscompares++;
         $display("FAIL reset_fwd: sr_q=%h cnt=%0d, expected sr_q=0 cnt=0", bus_f.sr_q, bus_f.flag_wr_cnt);
      end
      vectors++;
      if (bus_s.sr_q !== 4'h0 || bus_s.flag_wr_cnt !== 4'd0) begin
         miscompares++;
         $display("FAIL reset_stl: sr_q=%h cnt=%0d, expected sr_q=0 cnt=0", bus_s.sr_q, bus_s.flag_wr_cnt);
      end
      vectors++;
      if (bus_f.sr_id !== 4'h0 || bus_s.flag_hazard !== 1'b0 || bus_f.flag_hazard !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_idle: sr_id=%h hz_s=%b hz_f=%b, expected 0/0/0", bus_f.sr_id, bus_s.flag_hazard, bus_f.flag_hazard);
      end
   endtask

   task automatic test_write();
      do_reset();
      drive(1'b1, 1'b1, 4'b0100, 1'b0, 4'hE);
      step();
      vectors++;
      if (bus_f.sr_q !== 4'b0100 || bus_f.flag_wr_cnt !== 16'd1) begin
         miscompares++;
         $display("FAIL write: sr_q=%b cnt=%0d, expected 0100 cnt=1", bus_f.sr_q, bus_f.flag_wr_cnt);
      end
      @(negedge clk);
      drive(1'b1, 1'b0, 4'b1010, 1'b0, 4'hE);
      step();
      vectors++;
      if (bus_f.sr_q !== 4'b0100 || bus_f.flag_wr_cnt !== 16'd1) begin
         miscompares++;
         $display("FAIL write_no_s: sr_q=%b cnt=%0d, expected 0100 cnt=1", bus_f.sr_q, bus_f.flag_wr_cnt);
      end
      @(negedge clk);
      drive(1'b0, 1'b0, 4'h0, 1'b0, 4'hE);
   endtask

   task automatic test_forward();
      do_reset();
      drive(1'b1, 1'b1, 4'b0100, 1'b1, 4'b0000);
      #1;
      vectors++;
      if (bus_f.sr_id !== 4'b0100 || bus_f.flag_hazard !== 1'b0) begin
         miscompares++;
         $display("FAIL forward: sr_id=%b hz=%b, expected 0100/0", bus_f.sr_id, bus_f.flag_hazard);
      end
      vectors++;
      if (bus_f.sr_q !== 4'b0000) begin
         miscompares++;
         $display("FAIL forward_sr_q: sr_q=%b, expected 0000", bus_f.sr_q);
      end
      step();
      @(negedge clk);
      drive(1'b0, 1'b0, 4'h0, 1'b0, 4'hE);
   endtask

   task automatic test_hazard();
      do_reset();
      drive(1'b1, 1'b1, 4'b1000, 1'b1, 4'b0100);
      #1;
      vectors++;
      if (bus_s.flag_hazard !== 1'b1 || bus_s.sr_id !== 4'b0000) begin
         miscompares++;
         $display("FAIL hazard_raise: hz=%b sr_id=%b, expected 1/0000", bus_s.flag_hazard, bus_s.sr_id);
      end
      step();
      @(negedge clk);
      drive(1'b0, 1'b0, 4'h0, 1'b1, 4'b0100);
      #1;
      vectors++;
      if (bus_s.flag_hazard !== 1'b0 || bus_s.sr_id !== 4'b1000) begin
         miscompares++;
         $display("FAIL hazard_drop: hz=%b sr_id=%b, expected 0/1000", bus_s.flag_hazard, bus_s.sr_id);
      end
      drive(1'b1, 1'b1, 4'b1000, 1'b1, 4'b1110);
      #1;
      vectors++;
      if (bus_s.flag_hazard !== 1'b0) begin
         miscompares++;
         $display("FAIL hazard_al: hz=%b, expected 0", bus_s.flag_hazard);
      end
      drive(1'b1, 1'b1, 4'b1000, 1'b1, 4'b1111);
      #1;
      vectors++;
      if (bus_s.flag_hazard !== 1'b0) begin
         miscompares++;
         $display("FAIL hazard_nv: hz=%b, expected 0", bus_s.flag_hazard);
      end
      drive(1'b1, 1'b1, 4'b1000, 1'b0, 4'b0100);
      #1;
      vectors++;
      if (bus_s.flag_hazard !== 1'b0) begin
         miscompares++;
         $display("FAIL hazard_id_bubble: hz=%b, expected 0", bus_s.flag_hazard);
      end
      drive(1'b0, 1'b1, 4'b0110, 1'b1, 4'b0100);
      #1;
      vectors++;
      if (bus_s.flag_hazard !== 1'b0 || bus_f.sr_id !== 4'b1000) begin
         miscompares++;
         $display("FAIL hazard_flushed: hz=%b fwd_sr_id=%b, expected 0/1000", bus_s.flag_hazard, bus_f.sr_id);
      end
      @(negedge clk);
      drive(1'b0, 1'b0, 4'h0, 1'b0, 4'hE);
   endtask

   task automatic test_back_to_back();
      do_reset();
      drive(1'b1, 1'b1, 4'b0001, 1'b1, 4'b0000);
      step();
      @(negedge clk);
      drive(1'b1, 1'b1, 4'b0010, 1'b1, 4'b0000);
      #1;
      vectors++;
      if (bus_f.sr_q !== 4'b0001 || bus_f.sr_id !== 4'b0010) begin
         miscompares++;
         $display("FAIL b2b_bypass: sr_q=%b sr_id=%b, expected 0001/0010", bus_f.sr_q, bus_f.sr_id);
      end
      step();
      @(negedge clk);
      drive(1'b0, 1'b1, 4'b1111, 1'b1, 4'b0000);
      #1;
      vectors++;
      if (bus_f.sr_id !== 4'b0010) begin
         miscompares++;
         $display("FAIL b2b_flush_fwd: sr_id=%b, expected 0010", bus_f.sr_id);
      end
      step();
      vectors++;
      if (bus_f.sr_q !== 4'b0010 || bus_f.flag_wr_cnt !== 16'd2) begin
         miscompares++;
         $display("FAIL b2b_fwd: sr_q=%b cnt=%0d, expected 0010 cnt=2", bus_f.sr_q, bus_f.flag_wr_cnt);
      end
      vectors++;
      if (bus_s.sr_q !== 4'b0010 || bus_s.flag_wr_cnt !== 4'd2) begin
         miscompares++;
         $display("FAIL b2b_stl: sr_q=%b cnt=%0d, expected 0010 cnt=2", bus_s.sr_q, bus_s.flag_wr_cnt);
      end
      @(negedge clk);
      drive(1'b0, 1'b0, 4'h0, 1'b0, 4'hE);
   endtask

   task automatic test_saturation();
      int exp_s;
      do_reset();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         drive(1'b1, 1'b1, 4'(i + 1), 1'b0, 4'hE);
         step();
         exp_s = (i + 1 > 15) ? 15 : i + 1;
         vectors++;
         if (bus_s.flag_wr_cnt !== 4'(exp_s) || bus_s.sr_q !== 4'(i + 1)) begin
            miscompares++;
            $display("FAIL sat_step%0d: cnt=%0d sr_q=%h, expected cnt=%0d sr_q=%h",
                     i, bus_s.flag_wr_cnt, bus_s.sr_q, exp_s, 4'(i + 1));
         end
      end
      vectors++;
      if (bus_f.flag_wr_cnt !== 16'd20) begin
         miscompares++;
         $display("FAIL sat_wide: cnt=%0d, expected 20", bus_f.flag_wr_cnt);
      end
      @(negedge clk);
      rst_n = 1'b0;
      drive(1'b1, 1'b1, 4'hF, 1'b0, 4'hE);
      step();
      vectors++;
      if (bus_s.flag_wr_cnt !== 4'd0 || bus_s.sr_q !== 4'h0 || bus_f.flag_wr_cnt !== 16'd0) begin
         miscompares++;
         $display("FAIL sat_reset: cnt_s=%0d sr_q=%h cnt_f=%0d, expected 0/0/0",
                  bus_s.flag_wr_cnt, bus_s.sr_q, bus_f.flag_wr_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 1'b1, 4'b0110, 1'b0, 4'hE);
      step();
      vectors++;
      if (bus_s.flag_wr_cnt !== 4'd1 || bus_s.sr_q !== 4'b0110) begin
         miscompares++;
         $display("FAIL sat_restart: cnt=%0d sr_q=%b, expected 1/0110", bus_s.flag_wr_cnt, bus_s.sr_q);
      end
      @(negedge clk);
      drive(1'b0, 1'b0, 4'h0, 1'b0, 4'hE);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      drive(1'b0, 1'b0, 4'h0, 1'b0, 4'hE);
      test_reset();
      test_write();
      test_forward();
      test_hazard();
      test_back_to_back();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
